// File: rtl/uart_crc_checker_if.sv
// Frame-in / result-out bundle between the UART RX deserializer, the CRC checker and its consumers.
// The master side presents frames; the slave side (the checker) returns results.
interface uart_crc_checker_if;
  logic        frame_valid_i;
  logic [15:0] frame_i;
  logic        clr_cnt_i;
  logic [7:0]  data_o;
  logic        data_valid_o;
  logic        crc_err_o;
  logic        overrun_o;
  logic        busy_o;
  logic [15:0] err_cnt_o;

  modport master (
    output frame_valid_i, frame_i, clr_cnt_i,
    input  data_o, data_valid_o, crc_err_o, overrun_o, busy_o, err_cnt_o
  );

  modport slave (
    input  frame_valid_i, frame_i, clr_cnt_i,
    output data_o, data_valid_o, crc_err_o, overrun_o, busy_o, err_cnt_o
  );
endinterface

// File: rtl/uart_crc_checker.sv
// Bit-serial CRC-8 check of each RX frame; forwards a good data byte or flags an error (UART_CRC_ERR_CNT_EN adds an error counter).
// Latency: 9 cycles from frame accept to the data_valid_o/crc_err_o pulse.
// No backpressure: a frame arriving while busy is dropped and reported on overrun_o.
module uart_crc_checker #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input logic          clk,
  input logic          rst,
  uart_crc_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] crc;
  } frame_t;

  state_t     state;
  frame_t     frame_q;
  logic [7:0] crc_reg;
  logic [2:0] bit_cnt;
  logic [7:0] data_q;
  logic       data_vld_q;
  logic       crc_err_q;
  logic       overrun_q;
  logic       crc_match;

  assign crc_match = (crc_reg == frame_q.crc);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      frame_q    <= '0;
      crc_reg    <= 8'h00;
      bit_cnt    <= 3'd0;
      data_q     <= 8'h00;
      data_vld_q <= 1'b0;
      crc_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      data_vld_q <= 1'b0;
      crc_err_q  <= 1'b0;
      // Frames offered outside IDLE are dropped; the current frame continues untouched.
      overrun_q  <= bus.frame_valid_i && (state != IDLE);
      case (state)
        IDLE: begin
          if (bus.frame_valid_i) begin
            frame_q <= frame_t'(bus.frame_i);
            crc_reg <= INIT ^ bus.frame_i[15:8];
            bit_cnt <= 3'd0;
            state   <= CALC;
          end
        end
        CALC: begin
          crc_reg <= crc_reg[7] ? ({crc_reg[6:0], 1'b0} ^ POLY) : {crc_reg[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= DONE;
        end
        DONE: begin
          if (crc_match) begin
            data_q     <= frame_q.data;
            data_vld_q <= 1'b1;
          end else begin
            crc_err_q  <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_o       = data_q;
  assign bus.data_valid_o = data_vld_q;
  assign bus.crc_err_o    = crc_err_q;
  assign bus.overrun_o    = overrun_q;
  assign bus.busy_o       = (state != IDLE);

`ifdef UART_CRC_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Counts on the same edge that raises crc_err_o; a simultaneous clear takes priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt_q <= 16'h0000;
    end else if (bus.clr_cnt_i) begin
      err_cnt_q <= 16'h0000;
    end else if ((state == DONE) && !crc_match && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign bus.err_cnt_o = err_cnt_q;
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = bus.clr_cnt_i;
  assign bus.err_cnt_o  = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_crc_checker.sv
// Directed self-checking bench for uart_crc_checker with hand-computed CRC-8 (poly 0x07) vectors.
module tb_uart_crc_checker;

`ifdef UART_CRC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  uart_crc_checker_if bus_if ();

  uart_crc_checker #(.POLY(8'h07), .INIT(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cnt_exp(input int n);
    return CNT_EN ? 16'(n) : 16'h0000;
  endfunction

  // Offers one frame from IDLE and follows it through to the result pulse.
  task automatic send_frame(input logic [15:0] f, input logic good, input logic [7:0] exp_data,
                            input logic clr, input logic [15:0] exp_cnt);
    bus_if.frame_valid_i = 1'b1;
    bus_if.frame_i       = f;
    step();                                   // E0
    bus_if.frame_valid_i = 1'b0;
    check("busy_after_accept", 16'(bus_if.busy_o), 16'h1);
    for (int i = 1; i <= 8; i++) begin
      step();                                 // E1..E8
      check("no_early_valid", 16'(bus_if.data_valid_o), 16'h0);
      check("no_early_err", 16'(bus_if.crc_err_o), 16'h0);
      check("busy_in_calc", 16'(bus_if.busy_o), 16'h1);
    end
    bus_if.clr_cnt_i = clr;
    step();                                   // E9
    bus_if.clr_cnt_i = 1'b0;
    check("data_valid", 16'(bus_if.data_valid_o), 16'(good));
    check("crc_err", 16'(bus_if.crc_err_o), 16'(!good));
    check("data_o", 16'(bus_if.data_o), 16'(exp_data));
    check("busy_done", 16'(bus_if.busy_o), 16'h0);
    check("no_overrun", 16'(bus_if.overrun_o), 16'h0);
    check("err_cnt", bus_if.err_cnt_o, exp_cnt);
    step();
    check("valid_one_cycle", 16'(bus_if.data_valid_o), 16'h0);
    check("err_one_cycle", 16'(bus_if.crc_err_o), 16'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst                  = 1'b0;
    bus_if.frame_valid_i = 1'b0;
    bus_if.frame_i       = 16'h0000;
    bus_if.clr_cnt_i     = 1'b0;

    // Reset held for 3 cycles
    step(); step(); step();
    check("rst_data_o", 16'(bus_if.data_o), 16'h0);
    check("rst_data_valid", 16'(bus_if.data_valid_o), 16'h0);
    check("rst_crc_err", 16'(bus_if.crc_err_o), 16'h0);
    check("rst_overrun", 16'(bus_if.overrun_o), 16'h0);
    check("rst_busy", 16'(bus_if.busy_o), 16'h0);
    check("rst_err_cnt", bus_if.err_cnt_o, 16'h0);
    rst = 1'b1;
    step();

    send_frame(16'h55AC, 1'b1, 8'h55, 1'b0, cnt_exp(0));
    send_frame(16'h55AD, 1'b0, 8'h55, 1'b0, cnt_exp(1));
    send_frame(16'h0000, 1'b1, 8'h00, 1'b0, cnt_exp(1));
    send_frame(16'h0107, 1'b1, 8'h01, 1'b0, cnt_exp(1));

    // Overrun: second frame offered at E3 is dropped
    bus_if.frame_valid_i = 1'b1;
    bus_if.frame_i       = 16'h0107;
    step();                                   // E0
    bus_if.frame_valid_i = 1'b0;
    step(); step();                           // E1, E2
    bus_if.frame_valid_i = 1'b1;
    bus_if.frame_i       = 16'h55AC;
    step();                                   // E3
    bus_if.frame_valid_i = 1'b0;
    check("ovr_pulse", 16'(bus_if.overrun_o), 16'h1);
    check("ovr_busy", 16'(bus_if.busy_o), 16'h1);
    for (int i = 4; i <= 8; i++) begin
      step();
      check("ovr_pulse_once", 16'(bus_if.overrun_o), 16'h0);
      check("ovr_no_early_valid", 16'(bus_if.data_valid_o), 16'h0);
      check("ovr_busy_calc", 16'(bus_if.busy_o), 16'h1);
    end
    step();                                   // E9
    check("ovr_valid", 16'(bus_if.data_valid_o), 16'h1);
    check("ovr_data", 16'(bus_if.data_o), 16'h01);
    check("ovr_busy_drop", 16'(bus_if.busy_o), 16'h0);
    for (int i = 0; i < 12; i++) begin
      step();
      check("ovr_no_second_valid", 16'(bus_if.data_valid_o), 16'h0);
      check("ovr_no_err", 16'(bus_if.crc_err_o), 16'h0);
      check("ovr_idle", 16'(bus_if.busy_o), 16'h0);
    end
    check("ovr_data_hold", 16'(bus_if.data_o), 16'h01);

    // Counter: two more bad frames, then a fourth with clear on the increment edge
    send_frame(16'h01AA, 1'b0, 8'h01, 1'b0, cnt_exp(2));
    send_frame(16'h0006, 1'b0, 8'h01, 1'b0, cnt_exp(3));
    send_frame(16'h55AD, 1'b0, 8'h01, 1'b1, 16'h0000);

    // Reset asserted on cycle 4 of CALC
    bus_if.frame_valid_i = 1'b1;
    bus_if.frame_i       = 16'h55AC;
    step();                                   // E0
    bus_if.frame_valid_i = 1'b0;
    step(); step(); step();                   // E1..E3
    check("mid_busy_before", 16'(bus_if.busy_o), 16'h1);
    rst = 1'b0;
    step();                                   // E4
    rst = 1'b1;
    check("mid_rst_busy", 16'(bus_if.busy_o), 16'h0);
    check("mid_rst_data", 16'(bus_if.data_o), 16'h00);
    for (int i = 0; i < 10; i++) begin
      step();
      check("mid_no_valid", 16'(bus_if.data_valid_o), 16'h0);
      check("mid_no_err", 16'(bus_if.crc_err_o), 16'h0);
      check("mid_idle", 16'(bus_if.busy_o), 16'h0);
    end
    send_frame(16'h0107, 1'b1, 8'h01, 1'b0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_crc_checker.md
# uart_crc_checker

Receive-path stage directly downstream of the UART RX deserializer. Takes each received 16-bit frame (data byte + CRC-8 byte) and recomputes CRC-8 over the data byte with a bit-serial LFSR, one bit per clock. It then either forwards the data byte to the RX data register or flags a CRC error toward the error-interrupt logic.

## Interface
Parameters:
- POLY, 8'h07, CRC-8 generator polynomial (implicit x^8)
- INIT, 8'h00, CRC register seed loaded at frame accept

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
- frame_valid_i  input  1  one-cycle pulse: frame_i holds a complete received frame
- frame_i  input  16  [15:8] data byte, [7:0] received CRC byte
- data_o  output  8  last data byte that passed CRC; held until the next good frame
- data_valid_o  output  1  one-cycle pulse: data_o updated with a good byte
- crc_err_o  output  1  one-cycle pulse: CRC mismatch, frame discarded
- overrun_o  output  1  one-cycle pulse: frame_valid_i arrived while busy, frame dropped
- busy_o  output  1  high whenever state is not IDLE
- clr_cnt_i  input  1  clears the error counter (only used with UART_CRC_ERR_CNT_EN)
- err_cnt_o  output  16  CRC error count

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE with frame_valid_i=1 on an edge:
  - latch data and CRC bytes
  - crc_reg <= INIT ^ data byte
  - bit counter <= 0
  - go to CALC
- CALC, each edge:
  - crc_reg <= crc_reg[7] ? ((crc_reg<<1) ^ POLY) : (crc_reg<<1), with all arithmetic 8-bit and the MSB discarded
  - counter increments
  - after the 8th shift (counter == 7), go to DONE
- DONE, one cycle:
  - compare crc_reg with the latched CRC byte
  - match: data_o <= latched data, data_valid_o=1
  - mismatch: crc_err_o=1, data_o unchanged
  - return to IDLE
- frame_valid_i in CALC or DONE: frame ignored, overrun_o pulses on the next cycle, in-progress frame unaffected.
- data_valid_o and crc_err_o are never both high. Each accepted frame produces exactly one of them.
- Reset (any state, including mid-CALC):
  - state=IDLE, crc_reg=0, counter=0
  - data_o=8'h00, data_valid_o=0, crc_err_o=0, overrun_o=0, busy_o=0, err_cnt_o=0
  - the in-flight frame is lost, with no pulse emitted

## Timing
- Accept edge = E0. CALC occupies the edges E1..E8. The DONE compare result is registered on edge E9.
- data_valid_o / crc_err_o are high for exactly the cycle after E9, giving 9 cycles of latency from accept.
- busy_o is high from after E0 until after E9, i.e. 9 cycles per frame.
- The earliest next accept is E10, which is ample margin against the ~170k-clock UART frame period.
- overrun_o asserts one cycle after the ignored frame_valid_i edge.

## Configuration
- UART_CRC_ERR_CNT_EN defined:
  - err_cnt_o is a 16-bit counter that increments on every crc_err_o pulse and saturates at 16'hFFFF.
  - clr_cnt_i=1 sets it to 0 on the next edge.
  - If clear and increment occur in the same cycle, clear wins.
- UART_CRC_ERR_CNT_EN not defined: no counter is synthesised, err_cnt_o is tied to 16'h0000, and clr_cnt_i is ignored.

## Test plan
- Reset: hold rst=0 for 3 cycles. All outputs are 0 and busy_o=0.
- Good frame: frame_i=16'h55AC pulse. Nine cycles later data_valid_o pulses once with data_o=8'h55, and crc_err_o stays 0.
- Bad CRC: frame_i=16'h55AD. crc_err_o pulses at the same latency, data_o stays 8'h55, and err_cnt_o=1 when the macro is defined (0 when not).
- Edge values: frame_i=16'h0000 and then 16'h0107 both produce data_valid_o, with data_o=8'h00 and then 8'h01.
- Overrun: frame_i=16'h0107, then frame_i=16'h55AC 3 cycles later. overrun_o pulses, only data_o=8'h01 is delivered, and busy_o drops at the expected cycle.
- Reset mid-CALC: accept 16'h55AC, drive rst=0 on cycle 4. No data_valid_o or crc_err_o is emitted, the state is IDLE, and the next frame 16'h0107 processes normally.
- Counter (macro defined): 3 bad frames give err_cnt_o=3. Asserting clr_cnt_i together with a 4th crc_err_o pulse gives 0.
